// File: rtl/bus_master_if.sv
// Bus-master front end: turns one-shot core commands into an arbitrated req/grant bus access.
// Latency: at least 3 cycles from core_req to core_done; each grant-wait or ready-wait cycle adds one.
// Backpressure: commands are accepted only in IDLE (core_busy low) and are dropped otherwise; there is no queue.
// Optional feature macro: BUS_MASTER_TIMEOUT_EN bounds the access phase to TIMEOUT_CYCLES and reports core_err.
module bus_master_if #(
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic              bus_req_n,
    input  logic              bus_grnt_n,
    output logic              bus_as_n,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_n
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_n_q, bus_req_n_d;
    logic              bus_as_n_q, bus_as_n_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0] core_rd_data_q, core_rd_data_d;
    logic              core_busy_q, core_busy_d;
    logic              core_done_q, core_done_d;
    logic              core_err_q, core_err_d;
    logic              timeout_hit;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Access-phase cycle counter: zeroed as ACCESS is entered, counts every ACCESS/WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_REQ && !bus_grnt_n) begin
            cnt_d = '0;
        end else if (state_q == ST_ACCESS || state_q == ST_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle is the last one allowed in the access phase.
    assign timeout_hit = (state_q == ST_ACCESS || state_q == ST_WAIT) && (cnt_q == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output logic for the req/grant/strobe/ready handshake.
    always_comb begin
        state_d        = state_q;
        bus_req_n_d    = bus_req_n_q;
        bus_as_n_d     = bus_as_n_q;
        bus_rw_d       = bus_rw_q;
        bus_addr_d     = bus_addr_q;
        bus_wr_data_d  = bus_wr_data_q;
        core_rd_data_d = core_rd_data_q;
        core_done_d    = 1'b0;
        core_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (core_req) begin
                    bus_rw_d      = core_rw;
                    bus_addr_d    = core_addr;
                    bus_wr_data_d = core_wr_data;
                    bus_req_n_d   = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!bus_grnt_n) begin
                    bus_as_n_d = 1'b0;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS, ST_WAIT: begin
                // Strobe is a single-cycle pulse; grant is no longer looked at.
                bus_as_n_d = 1'b1;
                if (!bus_rdy_n) begin
                    if (bus_rw_q) begin
                        core_rd_data_d = bus_rd_data;
                    end
                    core_done_d = 1'b1;
                    bus_req_n_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    if (bus_rw_q) begin
                        core_rd_data_d = '0;
                    end
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                    bus_req_n_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction without a completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            bus_req_n_q    <= 1'b1;
            bus_as_n_q     <= 1'b1;
            bus_rw_q       <= 1'b1;
            bus_addr_q     <= '0;
            bus_wr_data_q  <= '0;
            core_rd_data_q <= '0;
            core_busy_q    <= 1'b0;
            core_done_q    <= 1'b0;
            core_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus_req_n_q    <= bus_req_n_d;
            bus_as_n_q     <= bus_as_n_d;
            bus_rw_q       <= bus_rw_d;
            bus_addr_q     <= bus_addr_d;
            bus_wr_data_q  <= bus_wr_data_d;
            core_rd_data_q <= core_rd_data_d;
            core_busy_q    <= core_busy_d;
            core_done_q    <= core_done_d;
            core_err_q     <= core_err_d;
        end
    end

    assign bus_req_n    = bus_req_n_q;
    assign bus_as_n     = bus_as_n_q;
    assign bus_rw       = bus_rw_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wr_data  = bus_wr_data_q;
    assign core_rd_data = core_rd_data_q;
    assign core_busy    = core_busy_q;
    assign core_done    = core_done_q;
    assign core_err     = core_err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: reset, fast read, delayed write, back-to-back, async reset, access limit.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// The access-limit scenario adapts to whether BUS_MASTER_TIMEOUT_EN is defined.
module tb_bus_master_if;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              core_req = 1'b0;
    logic              core_rw = 1'b1;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_wr_data = '0;
    logic [DATA_W-1:0] core_rd_data;
    logic              core_busy;
    logic              core_done;
    logic              core_err;
    logic              bus_req_n;
    logic              bus_grnt_n = 1'b1;
    logic              bus_as_n;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data = '0;
    logic              bus_rdy_n = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_master_if #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_err     (core_err),
        .bus_req_n    (bus_req_n),
        .bus_grnt_n   (bus_grnt_n),
        .bus_as_n     (bus_as_n),
        .bus_rw       (bus_rw),
        .bus_addr     (bus_addr),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .bus_rdy_n    (bus_rdy_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++; if (bus_req_n !== 1'b1) begin n_fail++; $display("FAIL rst_req_n got %b want 1", bus_req_n); end
        n_cmp++; if (bus_as_n !== 1'b1) begin n_fail++; $display("FAIL rst_as_n got %b want 1", bus_as_n); end
        n_cmp++; if (bus_rw !== 1'b1) begin n_fail++; $display("FAIL rst_rw got %b want 1", bus_rw); end
        n_cmp++; if (bus_addr !== 30'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus_addr); end
        n_cmp++; if (bus_wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data got %h want 0", bus_wr_data); end
        n_cmp++; if (core_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data got %h want 0", core_rd_data); end
        n_cmp++; if (core_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", core_busy); end
        n_cmp++; if (core_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", core_done); end
        n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", core_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read_fast();
        bus_grnt_n = 1'b0; bus_rdy_n = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h100; core_wr_data = '0;
        tick();
        core_req = 1'b0;
        // N+1
        n_cmp++; if (bus_req_n !== 1'b0) begin n_fail++; $display("FAIL rd_n1_req_n got %b want 0", bus_req_n); end
        n_cmp++; if (core_busy !== 1'b1) begin n_fail++; $display("FAIL rd_n1_busy got %b want 1", core_busy); end
        n_cmp++; if (bus_as_n !== 1'b1) begin n_fail++; $display("FAIL rd_n1_as_n got %b want 1", bus_as_n); end
        n_cmp++; if (bus_addr !== 30'h100) begin n_fail++; $display("FAIL rd_n1_addr got %h want 100", bus_addr); end
        n_cmp++; if (bus_rw !== 1'b1) begin n_fail++; $display("FAIL rd_n1_rw got %b want 1", bus_rw); end
        tick();
        // N+2
        n_cmp++; if (bus_as_n !== 1'b0) begin n_fail++; $display("FAIL rd_n2_as_n got %b want 0", bus_as_n); end
        n_cmp++; if (core_done !== 1'b0) begin n_fail++; $display("FAIL rd_n2_done got %b want 0", core_done); end
        tick();
        // N+3
        n_cmp++; if (core_done !== 1'b1) begin n_fail++; $display("FAIL rd_n3_done got %b want 1", core_done); end
        n_cmp++; if (core_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_n3_data got %h want deadbeef", core_rd_data); end
        n_cmp++; if (bus_req_n !== 1'b1) begin n_fail++; $display("FAIL rd_n3_req_n got %b want 1", bus_req_n); end
        n_cmp++; if (bus_as_n !== 1'b1) begin n_fail++; $display("FAIL rd_n3_as_n got %b want 1", bus_as_n); end
        n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL rd_n3_err got %b want 0", core_err); end
        tick();
        n_cmp++; if (core_done !== 1'b0) begin n_fail++; $display("FAIL rd_n4_done got %b want 0", core_done); end
        n_cmp++; if (core_busy !== 1'b0) begin n_fail++; $display("FAIL rd_n4_busy got %b want 0", core_busy); end
    endtask

    task automatic test_write_delayed();
        logic exp_req_n, exp_as_n, exp_done;
        bus_grnt_n = 1'b1; bus_rdy_n = 1'b1; bus_rd_data = 32'h5555_5555;
        core_req = 1'b1; core_rw = 1'b0; core_addr = 30'h2A5; core_wr_data = 32'h1234_5678;
        tick();
        core_req = 1'b0; core_addr = '0; core_wr_data = '1; core_rw = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            exp_req_n = (c <= 8) ? 1'b0 : 1'b1;
            exp_as_n  = (c == 6) ? 1'b0 : 1'b1;
            exp_done  = (c == 9);
            n_cmp++; if (bus_req_n !== exp_req_n) begin n_fail++; $display("FAIL wr_req_n c%0d got %b want %b", c, bus_req_n, exp_req_n); end
            n_cmp++; if (bus_as_n !== exp_as_n) begin n_fail++; $display("FAIL wr_as_n c%0d got %b want %b", c, bus_as_n, exp_as_n); end
            n_cmp++; if (core_done !== exp_done) begin n_fail++; $display("FAIL wr_done c%0d got %b want %b", c, core_done, exp_done); end
            n_cmp++; if (bus_addr !== 30'h2A5) begin n_fail++; $display("FAIL wr_addr c%0d got %h want 2a5", c, bus_addr); end
            n_cmp++; if (bus_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_data c%0d got %h want 12345678", c, bus_wr_data); end
            n_cmp++; if (bus_rw !== 1'b0) begin n_fail++; $display("FAIL wr_rw c%0d got %b want 0", c, bus_rw); end
            // Grant arrives after 4 cycles, then bounces high (must be ignored); ready 2 cycles after ACCESS.
            bus_grnt_n = (c == 5) ? 1'b0 : 1'b1;
            bus_rdy_n  = (c == 8) ? 1'b0 : 1'b1;
            tick();
        end
        n_cmp++; if (core_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_data_kept got %h want deadbeef", core_rd_data); end
        bus_grnt_n = 1'b0; bus_rdy_n = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_req_n, exp_as_n, exp_done, exp_busy;
        logic [ADDR_W-1:0] exp_addr;
        bus_grnt_n = 1'b0; bus_rdy_n = 1'b0; bus_rd_data = 32'hAAAA_0001;
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h10;
        tick();
        for (int c = 1; c <= 7; c++) begin
            exp_req_n = (c == 3 || c == 6 || c == 7) ? 1'b1 : 1'b0;
            exp_as_n  = (c == 2 || c == 5) ? 1'b0 : 1'b1;
            exp_done  = (c == 3 || c == 6);
            exp_busy  = !(c == 3 || c == 6 || c == 7);
            exp_addr  = (c <= 3) ? 30'h10 : 30'h055;
            n_cmp++; if (bus_req_n !== exp_req_n) begin n_fail++; $display("FAIL b2b_req_n c%0d got %b want %b", c, bus_req_n, exp_req_n); end
            n_cmp++; if (bus_as_n !== exp_as_n) begin n_fail++; $display("FAIL b2b_as_n c%0d got %b want %b", c, bus_as_n, exp_as_n); end
            n_cmp++; if (core_done !== exp_done) begin n_fail++; $display("FAIL b2b_done c%0d got %b want %b", c, core_done, exp_done); end
            n_cmp++; if (core_busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy c%0d got %b want %b", c, core_busy, exp_busy); end
            n_cmp++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr c%0d got %h want %h", c, bus_addr, exp_addr); end
            if (c >= 3) begin
                n_cmp++; if (core_rd_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_rd_data c%0d got %h want aaaa0001", c, core_rd_data); end
            end
            if (c >= 4) begin
                n_cmp++; if (bus_wr_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_wr_data c%0d got %h want cafef00d", c, bus_wr_data); end
                n_cmp++; if (bus_rw !== 1'b0) begin n_fail++; $display("FAIL b2b_rw c%0d got %b want 0", c, bus_rw); end
            end
            // Pulses while busy are dropped; the one in the done cycle is taken.
            if (c <= 2) begin
                core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h3FF;
            end else if (c == 3) begin
                core_req = 1'b1; core_rw = 1'b0; core_addr = 30'h055; core_wr_data = 32'hCAFE_F00D;
            end else begin
                core_req = 1'b0;
            end
            if (c >= 4) bus_rd_data = 32'h9999_9999;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus_grnt_n = 1'b0; bus_rdy_n = 1'b1; bus_rd_data = 32'h7777_7777;
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h123;
        tick();
        core_req = 1'b0;
        repeat (3) tick();
        n_cmp++; if (core_busy !== 1'b1) begin n_fail++; $display("FAIL rm_wait_busy got %b want 1", core_busy); end
        n_cmp++; if (bus_addr !== 30'h123) begin n_fail++; $display("FAIL rm_wait_addr got %h want 123", bus_addr); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus_req_n !== 1'b1) begin n_fail++; $display("FAIL rm_req_n got %b want 1", bus_req_n); end
        n_cmp++; if (bus_as_n !== 1'b1) begin n_fail++; $display("FAIL rm_as_n got %b want 1", bus_as_n); end
        n_cmp++; if (core_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", core_busy); end
        n_cmp++; if (bus_addr !== 30'h0) begin n_fail++; $display("FAIL rm_addr got %h want 0", bus_addr); end
        n_cmp++; if (bus_rw !== 1'b1) begin n_fail++; $display("FAIL rm_rw got %b want 1", bus_rw); end
        n_cmp++; if (core_rd_data !== 32'h0) begin n_fail++; $display("FAIL rm_rd_data got %h want 0", core_rd_data); end
        n_cmp++; if (core_done !== 1'b0) begin n_fail++; $display("FAIL rm_done got %b want 0", core_done); end
        bus_rdy_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (core_done !== 1'b0) begin n_fail++; $display("FAIL rm_hold_done c%0d got %b want 0", c, core_done); end
        end
        reset = 1'b1;
        bus_rd_data = 32'h1357_2468;
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h0ABC;
        tick();
        core_req = 1'b0;
        repeat (2) tick();
        n_cmp++; if (core_done !== 1'b1) begin n_fail++; $display("FAIL rm_after_done got %b want 1", core_done); end
        n_cmp++; if (core_rd_data !== 32'h1357_2468) begin n_fail++; $display("FAIL rm_after_data got %h want 13572468", core_rd_data); end
        n_cmp++; if (bus_addr !== 30'h0ABC) begin n_fail++; $display("FAIL rm_after_addr got %h want abc", bus_addr); end
        tick();
    endtask

`ifdef BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_done;
        // Ready never comes: the 8th access cycle ends the access with an error.
        bus_grnt_n = 1'b0; bus_rdy_n = 1'b1; bus_rd_data = 32'hFEED_FACE;
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h200;
        tick();
        core_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_done = (c == 10);
            n_cmp++; if (core_done !== exp_done) begin n_fail++; $display("FAIL to_done c%0d got %b want %b", c, core_done, exp_done); end
            n_cmp++; if (core_err !== exp_done) begin n_fail++; $display("FAIL to_err c%0d got %b want %b", c, core_err, exp_done); end
            if (c == 10) begin
                n_cmp++; if (core_rd_data !== 32'h0) begin n_fail++; $display("FAIL to_rd_data got %h want 0", core_rd_data); end
                n_cmp++; if (bus_req_n !== 1'b1) begin n_fail++; $display("FAIL to_req_n got %b want 1", bus_req_n); end
            end
            tick();
        end
        // Ready on the 8th access cycle beats the limit.
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h201;
        tick();
        core_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_done = (c == 10);
            n_cmp++; if (core_done !== exp_done) begin n_fail++; $display("FAIL to8_done c%0d got %b want %b", c, core_done, exp_done); end
            n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL to8_err c%0d got %b want 0", c, core_err); end
            if (c == 10) begin
                n_cmp++; if (core_rd_data !== 32'hFEED_FACE) begin n_fail++; $display("FAIL to8_rd_data got %h want feedface", core_rd_data); end
            end
            bus_rdy_n = (c == 9) ? 1'b0 : 1'b1;
            tick();
        end
    endtask
`else
    task automatic test_timeout();
        // Without the limit, WAIT holds for as long as ready stays high.
        bus_grnt_n = 1'b0; bus_rdy_n = 1'b1; bus_rd_data = 32'hFEED_FACE;
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h200;
        tick();
        core_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            n_cmp++; if (core_done !== 1'b0) begin n_fail++; $display("FAIL nto_done c%0d got %b want 0", c, core_done); end
            n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL nto_err c%0d got %b want 0", c, core_err); end
            n_cmp++; if (core_busy !== 1'b1) begin n_fail++; $display("FAIL nto_busy c%0d got %b want 1", c, core_busy); end
            bus_rdy_n = (c == 20) ? 1'b0 : 1'b1;
            tick();
        end
        n_cmp++; if (core_done !== 1'b1) begin n_fail++; $display("FAIL nto_final_done got %b want 1", core_done); end
        n_cmp++; if (core_err !== 1'b0) begin n_fail++; $display("FAIL nto_final_err got %b want 0", core_err); end
        n_cmp++; if (core_rd_data !== 32'hFEED_FACE) begin n_fail++; $display("FAIL nto_final_data got %h want feedface", core_rd_data); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read_fast();
        test_write_delayed();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
